// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 frame receiver.
//   ps2_state_t   - frame FSM states
//   START_BIT     - level of a valid start bit
//   STOP_BIT      - level of a valid stop bit
//   FRAME_BITS    - falling edges in one device-to-host frame
//   LAST_DATA_BIT - bit counter value of D7
//   parity_step() - one step of the running odd-parity accumulator
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_BITS = 2'd1,
        PARITY    = 2'd2,
        STOP      = 2'd3
    } ps2_state_t;

    localparam logic       START_BIT     = 1'b0;
    localparam logic       STOP_BIT      = 1'b1;
    localparam int         FRAME_BITS    = 11;
    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    // XOR-accumulate one received bit; after D0..D7 and the parity bit a
    // good frame leaves the accumulator at 1 (odd parity).
    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/ps2_frame_receiver_line_filter.sv
// ps2_line_filter: 2-flop synchroniser followed by a glitch filter for the
// PS/2 clock line. The filtered level only changes after FILTER_LEN
// consecutive synchronised samples disagree with it.
// Ports:
//   clk     in  system clock
//   RESET   in  asynchronous active-high reset (filtered level resets to 1)
//   clk_en  in  clock enable; all state advances only when high
//   line_in in  raw asynchronous line
//   level   out filtered line level
//   fall    out high in the clk_en tick in which the filtered level drops 1->0
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic RESET,
    input  logic clk_en,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int            CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;

    // The filtered level flips on the FILTER_LEN-th consecutive disagreeing
    // sample; a drop from 1 is reported in that same tick.
    assign fall  = clk_en && level_r && (sync2_r != level_r) && (cnt_r == CNT_LAST);
    assign level = level_r;

    // Synchroniser and disagreement counter for the glitch filter.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            cnt_r   <= '0;
        end else if (clk_en) begin
            sync1_r <= line_in;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: decodes PS/2 device-to-host frames
// (start, D0..D7 LSB first, odd parity, stop) into one byte per frame.
// Ports:
//   clk        in  system clock
//   RESET      in  asynchronous active-high reset
//   clk_en     in  clock enable; all state advances only when high
//   PS2_CLK    in  raw PS/2 clock line
//   PS2_DATA   in  raw PS/2 data line
//   DONE       out one-tick strobe: DATA holds a freshly received good byte
//   DATA       out last good byte, held until the next good frame
//   PARITY_ERR out one-tick strobe: frame had bad odd parity
//   FRAME_ERR  out one-tick strobe: stop bit was 0, or the frame timed out
//   BUSY       out high while a frame is in progress
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2000,
    parameter int TIMEOUT_W  = 12
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       DONE,
    output logic [7:0] DATA,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT);

    logic                 clk_level_unused_s;
    logic                 fall_s;
    logic                 data_sync1_r;
    logic                 data_sync2_r;
    ps2_state_t           state_r;
    logic [2:0]           bitcnt_r;
    logic [7:0]           shreg_r;
    logic                 par_acc_r;
    logic [TIMEOUT_W-1:0] to_cnt_r;
    logic                 done_r;
    logic [7:0]           data_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 busy_r;

    // Only the edge matters to the frame logic; the filtered level is spare.
    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .RESET  (RESET),
        .clk_en (clk_en),
        .line_in(PS2_CLK),
        .level  (clk_level_unused_s),
        .fall   (fall_s)
    );

    // Bare 2-flop synchroniser for the data line.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            data_sync1_r <= 1'b1;
            data_sync2_r <= 1'b1;
        end else if (clk_en) begin
            data_sync1_r <= PS2_DATA;
            data_sync2_r <= data_sync1_r;
        end
    end

    // Frame FSM with bit counter, shift register, parity, timeout and outputs.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_r   <= IDLE;
            bitcnt_r  <= 3'd0;
            shreg_r   <= 8'h00;
            par_acc_r <= 1'b0;
            to_cnt_r  <= '0;
            done_r    <= 1'b0;
            data_r    <= 8'h00;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else if (clk_en) begin
            done_r <= 1'b0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    to_cnt_r <= '0;
                    if (fall_s && (data_sync2_r == START_BIT)) begin
                        state_r   <= DATA_BITS;
                        busy_r    <= 1'b1;
                        bitcnt_r  <= 3'd0;
                        par_acc_r <= 1'b0;
                    end
                end
                default: begin
                    // A fall beats a timeout landing in the same tick.
                    if (fall_s) begin
                        to_cnt_r <= '0;
                        case (state_r)
                            DATA_BITS: begin
                                shreg_r   <= {data_sync2_r, shreg_r[7:1]};
                                par_acc_r <= parity_step(par_acc_r, data_sync2_r);
                                if (bitcnt_r == LAST_DATA_BIT) begin
                                    state_r <= PARITY;
                                end else begin
                                    bitcnt_r <= bitcnt_r + 3'd1;
                                end
                            end
                            PARITY: begin
                                par_acc_r <= parity_step(par_acc_r, data_sync2_r);
                                state_r   <= STOP;
                            end
                            STOP: begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                                // A bad stop bit reports only a framing error.
                                if (data_sync2_r != STOP_BIT) begin
                                    ferr_r <= 1'b1;
                                end else if (par_acc_r) begin
                                    data_r <= shreg_r;
                                    done_r <= 1'b1;
                                end else begin
                                    perr_r <= 1'b1;
                                end
                            end
                            default: begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        endcase
                    end else if (to_cnt_r == TIMEOUT_LIMIT) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        ferr_r   <= 1'b1;
                        to_cnt_r <= '0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TIMEOUT_W'(1);
                    end
                end
            endcase
        end
    end

    assign DONE       = done_r;
    assign DATA       = data_r;
    assign PARITY_ERR = perr_r;
    assign FRAME_ERR  = ferr_r;
    assign BUSY       = busy_r;

endmodule
